uart_tx_framer_seq: RTL and testbench

- Parametrised serial UART transmit framer. Replaces the combinational frame builder with a sequential engine.
- Accepts a data word and a per-frame configuration over a valid/ready handshake. Serialises start, data (LSB first), optional parity and stop bits, one bit per baud_tick.
- Sits between the TX data source/config registers and the tx pin. A one-deep pending slot allows gapless back-to-back frames.

---
 rtl/uart_tx_framer_seq.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_framer_seq.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer_seq.sv
// UART transmit framer: latches one configured frame per valid/ready handshake and
// shifts start, data (LSB first), optional parity and stop bits out on baud_tick.
module uart_tx_framer_seq #(
  parameter int DATA_MAX = 9,
  parameter int LEN_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                baud_tick,
  input  logic [DATA_MAX-1:0] data_in,
  input  logic [LEN_W-1:0]    data_len,
  input  logic [1:0]          parity_type,
  input  logic                stop_bits,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                tx,
  output logic                tx_active,
  output logic                frame_done,
  output logic                cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  // Everything the engine needs about a frame, resolved once at acceptance.
  typedef struct packed {
    logic [DATA_MAX-1:0] data;
    logic [LEN_W-1:0]    last_idx;
    logic                par_en;
    logic                par_bit;
    logic                two_stop;
  } frame_t;

  state_t           state, state_n;
  frame_t           cur, cur_n;
  frame_t           pend, pend_n;
  frame_t           in_frame;
  logic             pend_valid, pend_valid_n;
  logic [LEN_W-1:0] idx, idx_n;
  logic             tx_n, tx_active_n, frame_done_n, cfg_err_n;
  logic             len_ok, accept, take, final_stop, end_frame;
  logic             data_xor;

  function automatic logic tx_level(input state_t s, input frame_t f,
                                    input logic [LEN_W-1:0] bit_idx);
    case (s)
      S_START:  return 1'b0;
      S_DATA:   return f.data[bit_idx];
      S_PARITY: return f.par_bit;
      default:  return 1'b1;
    endcase
  endfunction

  assign len_ok = (data_len >= LEN_W'(5)) && (data_len <= LEN_W'(DATA_MAX));

  // Parity only covers the data_len LSBs; upper payload bits are don't-care.
  always_comb begin
    data_xor = 1'b0;
    for (int i = 0; i < DATA_MAX; i++) begin
      if (i < int'(data_len)) data_xor = data_xor ^ data_in[i];
    end
    in_frame.data     = data_in;
    in_frame.last_idx = data_len - LEN_W'(1);
    in_frame.par_en   = (parity_type == 2'b01) || (parity_type == 2'b10);
    in_frame.par_bit  = (parity_type == 2'b01) ? ~data_xor : data_xor;
    in_frame.two_stop = stop_bits;
  end

  assign final_stop = (state == S_STOP2) || ((state == S_STOP1) && !cur.two_stop);
  assign in_ready   = (state == S_IDLE) || (final_stop && !pend_valid);
  assign accept     = in_valid && in_ready;
  assign take       = accept && len_ok;
  assign end_frame  = final_stop && baud_tick;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves a value unassigned and infers a latch.
  always_comb begin
    state_n      = state;
    cur_n        = cur;
    idx_n        = idx;
    pend_n       = pend;
    pend_valid_n = pend_valid;
    frame_done_n = 1'b0;
    cfg_err_n    = accept && !len_ok;

    case (state)
      S_IDLE: begin
        if (take) begin
          cur_n   = in_frame;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (baud_tick) state_n = S_START;
      end
      S_START: begin
        if (baud_tick) begin
          state_n = S_DATA;
          idx_n   = '0;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (idx == cur.last_idx) state_n = cur.par_en ? S_PARITY : S_STOP1;
          else                     idx_n   = idx + LEN_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_tick) state_n = S_STOP1;
      end
      S_STOP1: begin
        if (baud_tick && cur.two_stop) state_n = S_STOP2;
      end
      default: ;
    endcase

    // A frame taken in the final stop state either chains straight into the
    // next start bit (same-cycle end) or waits in the pending slot.
    if (end_frame) begin
      frame_done_n = 1'b1;
      if (pend_valid) begin
        cur_n        = pend;
        pend_valid_n = 1'b0;
        state_n      = S_START;
      end else if (take) begin
        cur_n   = in_frame;
        state_n = S_START;
      end else begin
        state_n = S_IDLE;
      end
    end else if (take && (state != S_IDLE)) begin
      pend_n       = in_frame;
      pend_valid_n = 1'b1;
    end

    tx_n        = tx_level(state_n, cur_n, idx_n);
    tx_active_n = (state_n != S_IDLE) && (state_n != S_WAIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cur        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      idx        <= '0;
      tx         <= 1'b1;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      pend       <= pend_n;
      pend_valid <= pend_valid_n;
      idx        <= idx_n;
      tx         <= tx_n;
      tx_active  <= tx_active_n;
      frame_done <= frame_done_n;
      cfg_err    <= cfg_err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer_seq.sv
// Self-checking bench for uart_tx_framer_seq: directed frame table, multi-cycle
// corner sequences and randomized frames against a bit-stream reference model.
module tb_uart_tx_framer_seq;

  localparam int DATA_MAX = 9;
  localparam int LEN_W    = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                baud_tick = 1'b0;
  logic [DATA_MAX-1:0] data_in = '0;
  logic [LEN_W-1:0]    data_len = '0;
  logic [1:0]          parity_type = '0;
  logic                stop_bits = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready, tx, tx_active, frame_done, cfg_err;

  uart_tx_framer_seq #(.DATA_MAX(DATA_MAX), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .data_in    (data_in),
    .data_len   (data_len),
    .parity_type(parity_type),
    .stop_bits  (stop_bits),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .tx_active  (tx_active),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Baud strobe: one clk high every tick_div clocks, driven just after posedge.
  int tick_div = 4;
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt >= tick_div) cnt = 0;
      baud_tick = (cnt == 0);
    end
  end

  // Line monitor: the value on tx during a tick cycle is the bit that period carried.
  bit   obs[$];
  bit   exp_q[$];
  int   done_ticks[$];
  int   done_count = 0;
  int   cfg_count = 0;
  int   tick_count = 0;
  int   idle_cycles = 0;
  logic prev_tick = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_tick = 1'b0;
    end else begin
      if (frame_done) begin
        done_count++;
        done_ticks.push_back(tick_count);
        check("done_follows_tick", prev_tick, 1'b1);
      end
      if (cfg_err) cfg_count++;
      if (!tx_active) idle_cycles++;
      if (baud_tick) begin
        tick_count++;
        if (tx_active) obs.push_back(tx);
      end
      prev_tick = baud_tick;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1);
  end

  // Offers a frame, waits (bounded) for the handshake, then scrambles the inputs.
  task automatic send(input logic [8:0] d, input logic [3:0] len,
                      input logic [1:0] par, input logic st);
    int waited = 0;
    @(negedge clk);
    data_in     = d;
    data_len    = len;
    parity_type = par;
    stop_bits   = st;
    in_valid    = 1'b1;
    while (!in_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("handshake", (waited < 1000), 1'b1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    data_in     = DATA_MAX'($urandom);
    data_len    = LEN_W'($urandom);
    parity_type = 2'($urandom);
    stop_bits   = 1'($urandom);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_count < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, " done_in_budget"}, (done_count >= target), 1'b1);
  endtask

  task automatic compare_obs(input string name);
    int bad = -1;
    check({name, " bit_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      if (obs[i] !== exp_q[i] && bad < 0) bad = i;
    end
    check({name, " first_bad_bit"}, bad, -1);
  endtask

  // Reference model: the frame as a list of line levels, one per bit period.
  task automatic model_push(input logic [8:0] d, input int len,
                            input logic [1:0] par, input logic st);
    bit x = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(d[i]);
      x ^= d[i];
    end
    if (par == 2'b01)      exp_q.push_back(!x);
    else if (par == 2'b10) exp_q.push_back(x);
    exp_q.push_back(1'b1);
    if (st) exp_q.push_back(1'b1);
  endtask

  task automatic load_literal(input logic [19:0] bits, input int n);
    exp_q.delete();
    for (int k = n - 1; k >= 0; k--) exp_q.push_back(bits[k]);
  endtask

  typedef struct {
    logic [8:0]  data;
    logic [3:0]  len;
    logic [1:0]  par;
    logic        stop;
    logic [19:0] bits;   // line levels in tick order, first bit leftmost
    int          n;
  } vec_t;

  vec_t vec[6];

  initial begin
    int d0, c0, i0, dt0, n, legal, illegal;
    logic [3:0] bad_len, rl;
    logic [8:0] rd;
    logic [1:0] rp;
    logic       rs;
    bit         stayed_high;

    vec[0] = '{9'h0A5, 4'd8, 2'b10, 1'b0, 20'b0_10100101_0_1,   11};
    vec[1] = '{9'h041, 4'd7, 2'b01, 1'b1, 20'b0_1000001_1_11,   11};
    vec[2] = '{9'h1FF, 4'd9, 2'b11, 1'b0, 20'b0_111111111_1,    11};
    vec[3] = '{9'h013, 4'd5, 2'b10, 1'b0, 20'b0_11001_1_1,       8};
    vec[4] = '{9'h1E0, 4'd5, 2'b00, 1'b1, 20'b0_00000_11,        8};
    vec[5] = '{9'h00F, 4'd6, 2'b01, 1'b1, 20'b0_111100_1_11,    10};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst tx", tx, 1'b1);
    check("rst tx_active", tx_active, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    check("rst frame_done", frame_done, 1'b0);
    check("rst cfg_err", cfg_err, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frames.
    for (int t = 0; t < 6; t++) begin
      d0 = done_count;
      obs.delete();
      load_literal(vec[t].bits, vec[t].n);
      send(vec[t].data, vec[t].len, vec[t].par, vec[t].stop);
      wait_done(d0 + 1, 400, $sformatf("vec%0d", t));
      check($sformatf("vec%0d frame_done", t), frame_done, 1'b1);
      check($sformatf("vec%0d tx_active_after", t), tx_active, 1'b0);
      check($sformatf("vec%0d in_ready_after", t), in_ready, 1'b1);
      repeat (3 * tick_div) @(negedge clk);
      check($sformatf("vec%0d done_once", t), done_count - d0, 1);
      compare_obs($sformatf("vec%0d", t));
    end

    // Illegal lengths: rejected with a single cfg_err, line stays idle.
    for (int t = 0; t < 2; t++) begin
      bad_len = (t == 0) ? 4'd4 : 4'd10;
      c0 = cfg_count;
      d0 = done_count;
      stayed_high = 1'b1;
      obs.delete();
      send(9'h0FF, bad_len, 2'b10, 1'b0);
      check($sformatf("badlen%0d cfg_err_pulse", bad_len), cfg_err, 1'b1);
      repeat (4 * tick_div) begin
        @(negedge clk);
        if (!tx || tx_active || !in_ready) stayed_high = 1'b0;
      end
      check($sformatf("badlen%0d cfg_count", bad_len), cfg_count - c0, 1);
      check($sformatf("badlen%0d line_idle", bad_len), stayed_high, 1'b1);
      check($sformatf("badlen%0d no_frame", bad_len), done_count - d0, 0);
      check($sformatf("badlen%0d no_bits", bad_len), obs.size(), 0);
    end

    // Back-to-back through the pending slot.
    d0  = done_count;
    dt0 = done_ticks.size();
    obs.delete();
    load_literal(20'b0_00000000_1_0_11111111_1, 20);
    send(9'h000, 4'd8, 2'b00, 1'b0);
    n = 0;
    while (!tx_active && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    i0 = idle_cycles;
    send(9'h0FF, 4'd8, 2'b00, 1'b0);
    wait_done(d0 + 2, 400, "b2b");
    // Only the cycle carrying the second frame_done should see tx_active low.
    check("b2b idle_cycles", idle_cycles - i0, 1);
    check("b2b done_count", done_count - d0, 2);
    if (done_ticks.size() >= dt0 + 2)
      check("b2b done_spacing", done_ticks[dt0 + 1] - done_ticks[dt0], 10);
    else
      check("b2b done_pulses", done_ticks.size() - dt0, 2);
    compare_obs("b2b");

    // Reset in the middle of data bit 3, then a clean frame.
    obs.delete();
    send(9'h055, 4'd8, 2'b00, 1'b0);
    n = 0;
    while (obs.size() < 4 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("midrst reached_bit3", (obs.size() >= 4), 1'b1);
    @(posedge clk);
    #1;
    check("midrst pre tx_active", tx_active, 1'b1);
    check("midrst pre tx_bit3", tx, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst tx", tx, 1'b1);
    check("midrst tx_active", tx_active, 1'b0);
    check("midrst in_ready", in_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_count;
    obs.delete();
    load_literal(20'b0_10101010_1, 10);
    send(9'h055, 4'd8, 2'b00, 1'b0);
    wait_done(d0 + 1, 400, "postrst");
    repeat (2 * tick_div) @(negedge clk);
    check("postrst done_once", done_count - d0, 1);
    compare_obs("postrst");

    // Randomized frames against the reference model.
    tick_div = 3;
    d0 = done_count;
    c0 = cfg_count;
    legal = 0;
    illegal = 0;
    obs.delete();
    exp_q.delete();
    for (int f = 0; f < 60; f++) begin
      rd = 9'($urandom);
      rp = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: rl = 4'd0;
          1: rl = 4'd4;
          2: rl = 4'd10;
          default: rl = 4'd15;
        endcase
      end else begin
        rl = 4'($urandom_range(5, 9));
      end
      if (rl >= 4'd5 && rl <= 4'd9) begin
        model_push(rd, int'(rl), rp, rs);
        legal++;
      end else begin
        illegal++;
      end
      send(rd, rl, rp, rs);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    wait_done(d0 + legal, 5000, "rand");
    repeat (10) @(negedge clk);
    check("rand done_count", done_count - d0, legal);
    check("rand cfg_count", cfg_count - c0, illegal);
    check("rand idle_at_end", tx_active, 1'b0);
    compare_obs("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
